polyphonic_chime_sg: RTL and testbench

Multi-channel successor to the single-voice melody-chime sound generator. Each of C_CH voices has a programmable square-wave divider, a latched key-on, and an exponential-decay envelope with a selectable decay rate. The voices are summed into one saturated signed sample stream that feeds the existing audio DAC / delta-sigma stage. Time base comes from the shared 100 kHz and 1 kHz clock-enable strobes.

---
 rtl/polyphonic_chime_sg.sv | 142 ++++++++++++++
 tb/tb_polyphonic_chime_sg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphonic_chime_sg.sv
// Multi-voice chime generator: per-voice square divider, latched key-on and
// exponential-decay envelope, summed into one saturated signed sample stream.
module polyphonic_chime_sg #(
    parameter int C_CH       = 4,
    parameter int C_DIV_W    = 8,
    parameter int C_ENV_W    = 15,
    parameter int C_ENV_INIT = 28000,
    parameter int C_OUT_W    = 16,
    localparam int CH_W      = (C_CH > 1) ? $clog2(C_CH) : 1
) (
    input  logic               CK_i,
    input  logic               ARST_i,
    input  logic               WE_i,
    input  logic [CH_W-1:0]    CH_i,
    input  logic [C_DIV_W-1:0] DIV_LENs_i,
    input  logic [1:0]         DECAY_SEL_i,
    input  logic               SOUND_ON_i,
    input  logic               EE_100KHZ_i,
    input  logic               EE_1KHZ_i,
    output logic [C_OUT_W-1:0] WAVEs_o,
    output logic [C_CH-1:0]    ACTIVEs_o
);

    localparam int SUM_W = C_ENV_W + 1 + $clog2(C_CH);
    localparam int CMP_W = ((SUM_W > C_OUT_W) ? SUM_W : C_OUT_W) + 1;
    localparam logic signed [CMP_W-1:0] SAT_MAX =
        {{(CMP_W - C_OUT_W + 1){1'b0}}, {(C_OUT_W - 1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;

    // Write port: WE_i is a single-cycle strobe with no back-pressure; every
    // strobe whose CH_i addresses an existing voice is taken in that cycle.
    logic [C_DIV_W-1:0] div_len_q [C_CH];
    logic [C_DIV_W-1:0] div_len_d [C_CH];
    logic [1:0]         dsel_q    [C_CH];
    logic [1:0]         dsel_d    [C_CH];
    logic [C_DIV_W-1:0] sq_ctr_q  [C_CH];
    logic [C_DIV_W-1:0] sq_ctr_d  [C_CH];
    logic [C_ENV_W-1:0] env_q     [C_CH];
    logic [C_ENV_W-1:0] env_d     [C_CH];
    logic [C_CH-1:0]    pend_q, pend_d;
    logic [C_CH-1:0]    pol_q, pol_d;
    logic [C_CH-1:0]    active_q, active_d;
    logic [C_OUT_W-1:0] wave_q, wave_d;

    logic                      wr_sel;
    logic [C_ENV_W-1:0]        dec;
    logic signed [C_ENV_W:0]   sample;
    logic signed [SUM_W-1:0]   acc;
    logic signed [CMP_W-1:0]   acc_ext;

    always_comb begin
        div_len_d = div_len_q;
        dsel_d    = dsel_q;
        sq_ctr_d  = sq_ctr_q;
        env_d     = env_q;
        pend_d    = pend_q;
        pol_d     = pol_q;
        active_d  = '0;
        wr_sel    = 1'b0;
        dec       = '0;
        sample    = '0;
        acc       = '0;
        for (int c = 0; c < C_CH; c++) begin
            wr_sel = WE_i && (int'(CH_i) == c);

            if (EE_100KHZ_i) begin
                if (sq_ctr_q[c] == '0) begin
                    sq_ctr_d[c] = div_len_q[c];
                    pol_d[c]    = ~pol_q[c];
                end else begin
                    sq_ctr_d[c] = sq_ctr_q[c] - C_DIV_W'(1);
                end
            end

            // Step is ENV>>shift but never below 1, so ENV always reaches 0.
            dec = env_q[c] >> (4'd7 + {2'b00, dsel_q[c]});
            if (dec == '0) begin
                dec = C_ENV_W'(1);
            end
            if (EE_1KHZ_i) begin
                if (pend_q[c]) begin
                    env_d[c]  = C_ENV_W'(C_ENV_INIT);
                    pend_d[c] = 1'b0;
                end else if (env_q[c] != '0) begin
                    env_d[c] = env_q[c] - dec;
                end
            end

            // A key-on write overrides the tick updates of the same cycle.
            if (wr_sel) begin
                div_len_d[c] = DIV_LENs_i;
                dsel_d[c]    = DECAY_SEL_i;
                if (SOUND_ON_i) begin
                    pend_d[c]   = 1'b1;
                    sq_ctr_d[c] = DIV_LENs_i;
                    pol_d[c]    = 1'b0;
                end
            end

            active_d[c] = (env_q[c] != '0) | pend_q[c];
            sample = pol_q[c] ? -$signed({1'b0, env_q[c]}) : $signed({1'b0, env_q[c]});
            acc    = acc + SUM_W'(sample);
        end

        acc_ext = CMP_W'(acc);
        if (acc_ext > SAT_MAX) begin
            wave_d = SAT_MAX[C_OUT_W-1:0];
        end else if (acc_ext < SAT_MIN) begin
            wave_d = SAT_MIN[C_OUT_W-1:0];
        end else begin
            wave_d = acc_ext[C_OUT_W-1:0];
        end
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            for (int c = 0; c < C_CH; c++) begin
                div_len_q[c] <= '0;
                dsel_q[c]    <= '0;
                sq_ctr_q[c]  <= '0;
                env_q[c]     <= '0;
            end
            pend_q   <= '0;
            pol_q    <= '0;
            active_q <= '0;
            wave_q   <= '0;
        end else begin
            div_len_q <= div_len_d;
            dsel_q    <= dsel_d;
            sq_ctr_q  <= sq_ctr_d;
            env_q     <= env_d;
            pend_q    <= pend_d;
            pol_q     <= pol_d;
            active_q  <= active_d;
            wave_q    <= wave_d;
        end
    end

    assign WAVEs_o   = wave_q;
    assign ACTIVEs_o = active_q;

endmodule

// File: tb/tb_polyphonic_chime_sg.sv
// Bench for polyphonic_chime_sg: directed scenarios plus random traffic,
// every cycle compared against a voice-level behavioural model.
module tb_polyphonic_chime_sg;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, son = 1'b0, ee100 = 1'b0, ee1k = 1'b0;
    logic [1:0]  ch = '0;
    logic [7:0]  div = '0;
    logic [1:0]  dsel = '0;
    logic [15:0] wave;
    logic [3:0]  act;

    logic        g_we = 1'b0, g_son = 1'b0;
    logic [1:0]  g_ch = '0;
    logic [15:0] g_wave;
    logic [2:0]  g_act;

    int n_checks = 0;
    int n_fail   = 0;

    int m_div [NV];
    int m_dsel[NV];
    int m_pend[NV];
    int m_ctr [NV];
    int m_pol [NV];
    int m_env [NV];
    int exp_wave = 0;
    int exp_act  = 0;

    always #5 clk = ~clk;

    polyphonic_chime_sg dut (
        .CK_i(clk), .ARST_i(rst), .WE_i(we), .CH_i(ch), .DIV_LENs_i(div),
        .DECAY_SEL_i(dsel), .SOUND_ON_i(son), .EE_100KHZ_i(ee100), .EE_1KHZ_i(ee1k),
        .WAVEs_o(wave), .ACTIVEs_o(act)
    );

    polyphonic_chime_sg #(.C_CH(3)) dut_guard (
        .CK_i(clk), .ARST_i(rst), .WE_i(g_we), .CH_i(g_ch), .DIV_LENs_i(div),
        .DECAY_SEL_i(dsel), .SOUND_ON_i(g_son), .EE_100KHZ_i(ee100), .EE_1KHZ_i(ee1k),
        .WAVEs_o(g_wave), .ACTIVEs_o(g_act)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(obs), $signed(expv), $time);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NV; c++) begin
            m_div[c] = 0; m_dsel[c] = 0; m_pend[c] = 0;
            m_ctr[c] = 0; m_pol[c] = 0; m_env[c] = 0;
        end
        exp_wave = 0;
        exp_act  = 0;
    endtask

    // One clock of the voice rules: outputs reflect the state before the edge.
    task automatic model_update();
        int s;
        int a;
        int d;
        s = 0;
        a = 0;
        for (int c = 0; c < NV; c++) begin
            s += (m_pol[c] != 0) ? -m_env[c] : m_env[c];
            if (m_env[c] != 0 || m_pend[c] != 0) a |= (1 << c);
        end
        exp_wave = clamp16(s);
        exp_act  = a;
        for (int c = 0; c < NV; c++) begin
            if (ee100) begin
                if (m_ctr[c] == 0) begin
                    m_ctr[c] = m_div[c];
                    m_pol[c] = 1 - m_pol[c];
                end else begin
                    m_ctr[c] = m_ctr[c] - 1;
                end
            end
            if (ee1k) begin
                if (m_pend[c] != 0) begin
                    m_env[c]  = 28000;
                    m_pend[c] = 0;
                end else if (m_env[c] != 0) begin
                    d = m_env[c] / (1 << (7 + m_dsel[c]));
                    if (d < 1) d = 1;
                    m_env[c] = m_env[c] - d;
                end
            end
            if (we && int'(ch) == c) begin
                m_div[c]  = int'(div);
                m_dsel[c] = int'(dsel);
                if (son) begin
                    m_pend[c] = 1;
                    m_ctr[c]  = int'(div);
                    m_pol[c]  = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        check("wave_model", $signed(wave), exp_wave);
        check("active_model", {28'b0, act}, exp_act);
        we = 1'b0; son = 1'b0; ee100 = 1'b0; ee1k = 1'b0;
        g_we = 1'b0; g_son = 1'b0;
    endtask

    task automatic wr(input int c, input int d, input int s, input bit on);
        we   = 1'b1;
        ch   = 2'(c);
        div  = 8'(d);
        dsel = 2'(s);
        son  = on;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_wave", $signed(wave), 0);
        check("rst_active", {28'b0, act}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("init_wave", $signed(wave), 0);
        check("init_active", {28'b0, act}, 0);
        check("init_g_active", {29'b0, g_act}, 0);
        rst = 1'b0;

        // Out-of-range voice on a 3-voice instance is ignored entirely.
        g_we = 1'b1; g_ch = 2'd3; g_son = 1'b1; div = 8'd7;
        step();
        repeat (3) begin ee1k = 1'b1; step(); end
        check("guard_active", {29'b0, g_act}, 0);
        check("guard_wave", $signed(g_wave), 0);
        g_we = 1'b1; g_ch = 2'd2; g_son = 1'b1;
        step();
        check("guard_valid_early", {29'b0, g_act}, 0);
        step();
        check("guard_valid_active", {29'b0, g_act}, 3'b100);

        // Square period: DIV_LEN=3 gives a half period of 4 ticks.
        do_reset();
        wr(0, 3, 2, 1'b1); step();
        ee1k = 1'b1; step();
        step();
        check("sq_start", $signed(wave), 28000);
        for (int k = 1; k <= 12; k++) begin
            ee100 = 1'b1; step();
            step();
            check("sq_phase", $signed(wave), ((k / 4) % 2 == 1) ? -28000 : 28000);
            repeat (8) step();
        end

        // Mid-note reset silences at once and stays silent.
        do_reset();
        repeat (5) begin ee1k = 1'b1; ee100 = 1'b1; step(); end
        check("post_rst_wave", $signed(wave), 0);

        // Decay values for DSEL=2 and DSEL=0, then run to zero.
        wr(1, 5, 2, 1'b1); step();
        ee1k = 1'b1; step();
        step();
        check("decay_load", $signed(wave), 28000);
        ee1k = 1'b1; step();
        step();
        check("decay_sel2", $signed(wave), 27946);
        wr(1, 5, 0, 1'b1); step();
        ee1k = 1'b1; step();
        ee1k = 1'b1; step();
        step();
        check("decay_sel0", $signed(wave), 27782);
        for (int i = 0; i < 3000 && m_env[1] != 0; i++) begin
            ee1k = 1'b1; step();
        end
        check("decay_reaches_zero", m_env[1], 0);
        step();
        check("decay_active_fall", {28'b0, act}, 0);
        check("decay_wave_zero", $signed(wave), 0);

        // Key-on latch: same-cycle 1 kHz tick does not load.
        do_reset();
        wr(2, 10, 1, 1'b1); ee1k = 1'b1; step();
        check("latch_early", {28'b0, act}, 0);
        step();
        check("latch_active", {28'b0, act}, 4'b0100);
        check("latch_no_load", $signed(wave), 0);
        repeat (497) step();
        check("latch_still_silent", $signed(wave), 0);
        ee1k = 1'b1; step();
        step();
        check("latch_load", $signed(wave), 28000);

        // Saturation with all four voices.
        do_reset();
        for (int c = 0; c < NV; c++) begin wr(c, 0, 3, 1'b1); step(); end
        ee1k = 1'b1; step();
        step();
        check("sat_pos", $signed(wave), 32767);
        ee100 = 1'b1; step();
        step();
        check("sat_neg", $signed(wave), -32768);
        wr(2, 0, 3, 1'b1); step();
        wr(3, 0, 3, 1'b1); step();
        step();
        check("sat_cancel", $signed(wave), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0)
                wr($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0);
            ee100 = ($urandom_range(0, 3) == 0);
            ee1k  = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
